// File: rtl/pool2x2_stream_engine_if.sv
// Stream bundle for pool2x2_stream_engine: input beats, pooled output beats and frame_done.
// The engine connects through the slave modport; the producer/consumer side uses master.
interface pool2x2_stream_engine_if #(
   parameter int DATA_W = 8,
   parameter int CH_W   = 1
);
   logic                     valid_in;
   logic                     ready_in;
   logic signed [DATA_W-1:0] pixel_in;
   logic                     valid_out;
   logic                     ready_out;
   logic signed [DATA_W-1:0] pixel_out;
   logic        [CH_W-1:0]   ch_out;
   logic                     frame_done;

   modport master (
      output valid_in, pixel_in, ready_out,
      input  ready_in, valid_out, pixel_out, ch_out, frame_done
   );

   modport slave (
      input  valid_in, pixel_in, ready_out,
      output ready_in, valid_out, pixel_out, ch_out, frame_done
   );
endinterface

// File: rtl/pool2x2_stream_engine.sv
// Streaming 2x2 stride-2 max/average pooling over channel-interleaved row-major frames.
// Optional macro POOL_RELU_EN clamps negative pooled results to zero before the output register.
module pool2x2_stream_engine #(
   parameter int DATA_W   = 8,
   parameter int MAP_W    = 28,
   parameter int MAP_H    = 28,
   parameter int CHANNELS = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   mode,
   pool2x2_stream_engine_if.slave bus
);
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int COL_W     = $clog2(MAP_W);
   localparam int ROW_W     = $clog2(MAP_H);
   localparam int LB_DEPTH  = (MAP_W / 2) * CHANNELS;
   localparam int LB_W      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
   localparam int OUT_TOTAL = (MAP_W / 2) * (MAP_H / 2) * CHANNELS;
   localparam int OCNT_W    = $clog2(OUT_TOTAL + 1);

   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(CHANNELS - 1);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(MAP_W - 1);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(MAP_H - 1);
   localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OUT_TOTAL - 1);

   logic [CH_W-1:0]          ch_r;
   logic [COL_W-1:0]         col_r;
   logic [ROW_W-1:0]         row_r;
   logic                     mode_r;
   logic signed [DATA_W-1:0] hreg_r [CHANNELS];
   logic signed [DATA_W:0]   lb_r   [LB_DEPTH];

   logic                     valid_out_r;
   logic signed [DATA_W-1:0] pixel_out_r;
   logic [CH_W-1:0]          ch_out_r;
   logic                     frame_done_r;
   logic [OCNT_W-1:0]        ocnt_r;

   logic                     ready_in_s;
   logic                     accept_s;
   logic                     first_s;
   logic                     mode_s;
   logic                     produce_s;
   logic                     fire_s;
   int                       lb_pos_s;
   logic [LB_W-1:0]          lb_idx_s;
   logic signed [DATA_W-1:0] pix_s;
   logic signed [DATA_W-1:0] hold_s;
   logic signed [DATA_W:0]   pair_s;
   logic signed [DATA_W:0]   top_s;
   logic signed [DATA_W+1:0] sum4_s;
   logic signed [DATA_W-1:0] pooled_s;
   logic signed [DATA_W-1:0] result_s;

   assign ready_in_s     = !valid_out_r || bus.ready_out;
   assign accept_s       = bus.valid_in && ready_in_s && !clear;
   assign first_s        = (row_r == {ROW_W{1'b0}}) && (col_r == {COL_W{1'b0}}) && (ch_r == {CH_W{1'b0}});
   // The first beat of a frame uses the live mode pin; later beats use the latched copy.
   assign mode_s         = first_s ? mode : mode_r;
   assign produce_s      = row_r[0] && col_r[0];
   assign fire_s         = valid_out_r && bus.ready_out;

   assign bus.ready_in   = ready_in_s;
   assign bus.valid_out  = valid_out_r;
   assign bus.pixel_out  = pixel_out_r;
   assign bus.ch_out     = ch_out_r;
   assign bus.frame_done = frame_done_r;

   // Horizontal pair reduction, vertical combine with the line buffer, optional clamp.
   always_comb begin
      pix_s    = bus.pixel_in;
      hold_s   = hreg_r[ch_r];
      lb_pos_s = (int'(col_r) >> 1) * CHANNELS + int'(ch_r);
      lb_idx_s = LB_W'(lb_pos_s);
      top_s    = lb_r[lb_idx_s];
      if (mode_s) begin
         pair_s = {hold_s[DATA_W-1], hold_s} + {pix_s[DATA_W-1], pix_s};
      end else if (hold_s > pix_s) begin
         pair_s = {hold_s[DATA_W-1], hold_s};
      end else begin
         pair_s = {pix_s[DATA_W-1], pix_s};
      end
      sum4_s = {pair_s[DATA_W], pair_s} + {top_s[DATA_W], top_s};
      if (mode_s) begin
         pooled_s = DATA_W'(sum4_s >>> 2);
      end else if (pair_s > top_s) begin
         pooled_s = DATA_W'(pair_s);
      end else begin
         pooled_s = DATA_W'(top_s);
      end
`ifdef POOL_RELU_EN
      if (pooled_s < 0) begin
         result_s = {DATA_W{1'b0}};
      end else begin
         result_s = pooled_s;
      end
`else
      result_s = pooled_s;
`endif
   end

   // Channel/column/row position counters and per-frame mode latch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_r   <= {CH_W{1'b0}};
         col_r  <= {COL_W{1'b0}};
         row_r  <= {ROW_W{1'b0}};
         mode_r <= 1'b0;
      end else if (clear) begin
         ch_r  <= {CH_W{1'b0}};
         col_r <= {COL_W{1'b0}};
         row_r <= {ROW_W{1'b0}};
      end else if (accept_s) begin
         mode_r <= mode_s;
         if (ch_r == CH_LAST) begin
            ch_r <= {CH_W{1'b0}};
            if (col_r == COL_LAST) begin
               col_r <= {COL_W{1'b0}};
               if (row_r == ROW_LAST) begin
                  row_r <= {ROW_W{1'b0}};
               end else begin
                  row_r <= row_r + ROW_W'(1'b1);
               end
            end else begin
               col_r <= col_r + COL_W'(1'b1);
            end
         end else begin
            ch_r <= ch_r + CH_W'(1'b1);
         end
      end
   end

   // Per-channel horizontal hold registers and the top-row line buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            hreg_r[i] <= {DATA_W{1'b0}};
         end
         for (int i = 0; i < LB_DEPTH; i++) begin
            lb_r[i] <= {(DATA_W + 1){1'b0}};
         end
      end else if (accept_s) begin
         if (!col_r[0]) begin
            hreg_r[ch_r] <= pix_s;
         end else if (!row_r[0]) begin
            lb_r[lb_idx_s] <= pair_s;
         end
      end
   end

   // Output register, output beat counter and frame_done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out_r  <= 1'b0;
         pixel_out_r  <= {DATA_W{1'b0}};
         ch_out_r     <= {CH_W{1'b0}};
         frame_done_r <= 1'b0;
         ocnt_r       <= {OCNT_W{1'b0}};
      end else if (clear) begin
         valid_out_r  <= 1'b0;
         frame_done_r <= 1'b0;
         ocnt_r       <= {OCNT_W{1'b0}};
      end else begin
         frame_done_r <= fire_s && (ocnt_r == OCNT_LAST);
         if (fire_s) begin
            if (ocnt_r == OCNT_LAST) begin
               ocnt_r <= {OCNT_W{1'b0}};
            end else begin
               ocnt_r <= ocnt_r + OCNT_W'(1'b1);
            end
         end
         if (accept_s && produce_s) begin
            valid_out_r <= 1'b1;
            pixel_out_r <= result_s;
            ch_out_r    <= ch_r;
         end else if (bus.ready_out) begin
            valid_out_r <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pool2x2_stream_engine.sv
// Scoreboard bench: two engines (4x4x1 and 5x5x2) fed directed and random frames;
// expectations come from a window-level pooling model, a negedge monitor pops and compares.
module tb_pool2x2_stream_engine;
   localparam int DW = 8;

   typedef struct {
      int pix;
      int ch;
      bit last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear_a, clear_b, mode_a, mode_b;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t qa[$];
   exp_t qb[$];
   bit   pend_done[2];
   int   rdy_mode[2] = '{0, 0};
   int   px[$];

   pool2x2_stream_engine_if #(.DATA_W(DW), .CH_W(1)) ifa ();
   pool2x2_stream_engine_if #(.DATA_W(DW), .CH_W(1)) ifb ();

   pool2x2_stream_engine #(.DATA_W(DW), .MAP_W(4), .MAP_H(4), .CHANNELS(1)) dut_a (
      .clk(clk), .rst(rst), .clear(clear_a), .mode(mode_a), .bus(ifa.slave));
   pool2x2_stream_engine #(.DATA_W(DW), .MAP_W(5), .MAP_H(5), .CHANNELS(2)) dut_b (
      .clk(clk), .rst(rst), .clear(clear_b), .mode(mode_b), .bus(ifb.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? qa.size() : qb.size();
   endfunction

   function automatic void qpush(input int d, input exp_t e);
      if (d == 0) qa.push_back(e);
      else qb.push_back(e);
   endfunction

   // Pooling reference: gathers each 2x2 window straight from the frame array.
   function automatic void model(input int d, input int w, input int h, input int c,
                                 input int f[$], input bit avg);
      exp_t e;
      for (int r = 0; r < h / 2; r++)
         for (int x = 0; x < w / 2; x++)
            for (int k = 0; k < c; k++) begin
               int v[4];
               int res;
               int s;
               v[0] = f[((2*r)   * w + 2*x)   * c + k];
               v[1] = f[((2*r)   * w + 2*x+1) * c + k];
               v[2] = f[((2*r+1) * w + 2*x)   * c + k];
               v[3] = f[((2*r+1) * w + 2*x+1) * c + k];
               if (avg) begin
                  s = v[0] + v[1] + v[2] + v[3];
                  res = s / 4;
                  if ((s % 4 != 0) && (s < 0)) res = res - 1;
               end else begin
                  res = v[0];
                  for (int j = 1; j < 4; j++) if (v[j] > res) res = v[j];
               end
`ifdef POOL_RELU_EN
               if (res < 0) res = 0;
`endif
               e.pix  = res;
               e.ch   = k;
               e.last = (r == h/2 - 1) && (x == w/2 - 1) && (k == c - 1);
               qpush(d, e);
            end
   endfunction

   task automatic set_in(input int d, input bit v, input int p, input bit m, input bit cl);
      if (d == 0) begin
         ifa.valid_in = v; ifa.pixel_in = DW'(p); mode_a = m; clear_a = cl;
      end else begin
         ifb.valid_in = v; ifb.pixel_in = DW'(p); mode_b = m; clear_b = cl;
      end
   endtask

   task automatic wait_accept(input int d);
      int t = 0;
      bit acc = 1'b0;
      while (!acc && t < 200) begin
         @(negedge clk);
         acc = (d == 0) ? ifa.ready_in : ifb.ready_in;
         @(posedge clk);
         #1;
         t++;
      end
      if (!acc) begin
         n_checks++;
         n_fail++;
         $display("FAIL accept_timeout[%0d]: got ready_in=0 for 200 cycles, expected 1", d);
      end
   endtask

   // Sends the first n beats; mode is the frame mode on beat 0 and random afterwards.
   task automatic send_frame(input int d, input int f[$], input bit m, input bit gaps, input int n);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            set_in(d, 1'b0, 0, 1'($urandom_range(0, 1)), 1'b0);
            @(posedge clk);
            #1;
         end
         set_in(d, 1'b1, f[i], (i == 0) ? m : 1'($urandom_range(0, 1)), 1'b0);
         wait_accept(d);
      end
      set_in(d, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic drain(input int d);
      int t = 0;
      while (qsize(d) != 0 && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (qsize(d) != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout[%0d]: got %0d outputs pending, expected 0", d, qsize(d));
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic ramp(input int n);
      px.delete();
      for (int i = 0; i < n; i++) px.push_back(i);
   endtask

   task automatic rand_frame(input int n);
      px.delete();
      for (int i = 0; i < n; i++) px.push_back(int'($urandom_range(0, 255)) - 128);
   endtask

   function automatic bit pick_ready(input int d);
      case (rdy_mode[d])
         0:       return 1'b1;
         1:       return 1'($urandom_range(0, 1));
         default: return 1'b0;
      endcase
   endfunction

   initial begin
      ifa.ready_out = 1'b1;
      ifb.ready_out = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         ifa.ready_out = pick_ready(0);
         ifb.ready_out = pick_ready(1);
      end
   end

   task automatic mon(input int d, input logic v, input logic r, input int p, input int c, input logic fd);
      exp_t e;
      bit   fire_last = 1'b0;
      chk($sformatf("frame_done[%0d]", d), int'(fd), int'(pend_done[d]));
      if (v) begin
         if (qsize(d) == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out[%0d]: got pixel=%0d ch=%0d, expected no output", d, p, c);
         end else begin
            e = (d == 0) ? qa[0] : qb[0];
            chk($sformatf("pixel_out[%0d]", d), p, e.pix);
            chk($sformatf("ch_out[%0d]", d), c, e.ch);
            if (r) begin
               if (d == 0) void'(qa.pop_front());
               else void'(qb.pop_front());
               fire_last = e.last;
            end
         end
      end
      pend_done[d] = fire_last;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, ifa.valid_out, ifa.ready_out, int'(ifa.pixel_out), int'(ifa.ch_out), ifa.frame_done);
         mon(1, ifb.valid_out, ifb.ready_out, int'(ifb.pixel_out), int'(ifb.ch_out), ifb.frame_done);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      set_in(0, 1'b0, 0, 1'b0, 1'b0);
      set_in(1, 1'b0, 0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid_out_a", int'(ifa.valid_out), 0);
      chk("rst_pixel_out_a", int'(ifa.pixel_out), 0);
      chk("rst_ch_out_a", int'(ifa.ch_out), 0);
      chk("rst_frame_done_a", int'(ifa.frame_done), 0);
      chk("rst_ready_in_a", int'(ifa.ready_in), 1);
      chk("rst_valid_out_b", int'(ifb.valid_out), 0);
      chk("rst_ready_in_b", int'(ifb.ready_in), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Max ramp, average window pattern, then ramp under random backpressure.
      ramp(16);
      model(0, 4, 4, 1, px, 1'b0);
      send_frame(0, px, 1'b0, 1'b0, 16);
      drain(0);
      px = '{-3, -2, 4, 4, -1, 1, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
      model(0, 4, 4, 1, px, 1'b1);
      send_frame(0, px, 1'b1, 1'b0, 16);
      drain(0);
      rdy_mode[0] = 1;
      ramp(16);
      model(0, 4, 4, 1, px, 1'b0);
      send_frame(0, px, 1'b0, 1'b0, 16);
      drain(0);
      rdy_mode[0] = 0;

      // Abort after five beats; the beat presented alongside clear is dropped.
      ramp(16);
      send_frame(0, px, 1'b0, 1'b0, 5);
      set_in(0, 1'b1, 99, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      set_in(0, 1'b0, 0, 1'b0, 1'b0);
      model(0, 4, 4, 1, px, 1'b0);
      send_frame(0, px, 1'b0, 1'b0, 16);
      drain(0);

      // Stall a finished window, then reset asynchronously mid-frame.
      rdy_mode[0] = 2;
      @(posedge clk);
      #1;
      e.pix = 5; e.ch = 0; e.last = 1'b0;
      qpush(0, e);
      send_frame(0, px, 1'b0, 1'b0, 6);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_valid_out", int'(ifa.valid_out), 0);
      chk("async_rst_pixel_out", int'(ifa.pixel_out), 0);
      chk("async_rst_ready_in", int'(ifa.ready_in), 1);
      qa.delete();
      pend_done[0] = 1'b0;
      rdy_mode[0] = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ramp(16);
      model(0, 4, 4, 1, px, 1'b0);
      send_frame(0, px, 1'b0, 1'b0, 16);
      drain(0);

      // All-negative frame: negatives pass through unless the clamp is built in.
      px.delete();
      for (int i = 0; i < 16; i++) px.push_back(-1 - i * 7);
      model(0, 4, 4, 1, px, 1'b0);
      send_frame(0, px, 1'b0, 1'b0, 16);
      drain(0);

      // Random back-to-back frames with gaps, backpressure and mid-frame mode churn.
      rdy_mode[0] = 1;
      for (int k = 0; k < 8; k++) begin
         bit m;
         m = 1'($urandom_range(0, 1));
         rand_frame(16);
         model(0, 4, 4, 1, px, m);
         send_frame(0, px, m, 1'b1, 16);
      end
      drain(0);
      rdy_mode[0] = 0;

      // Odd 5x5 map with two channels: ch0 = index, ch1 = -index.
      px.delete();
      for (int i = 0; i < 25; i++) begin
         px.push_back(i);
         px.push_back(-i);
      end
      model(1, 5, 5, 2, px, 1'b0);
      send_frame(1, px, 1'b0, 1'b0, 50);
      drain(1);
      rdy_mode[1] = 1;
      for (int k = 0; k < 6; k++) begin
         bit m;
         m = 1'($urandom_range(0, 1));
         rand_frame(50);
         model(1, 5, 5, 2, px, m);
         send_frame(1, px, m, 1'b1, 50);
      end
      drain(1);
      rdy_mode[1] = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
